// File: rtl/sysbus_pkg.sv
// Sysbus shared definitions.
// Purpose: tag field encodings, the tag layout, the responder state type and
// the cache-line geometry used by the responder, its memory and the bench.
// Ports: none (package).
package sysbus_pkg;

    localparam logic       READ       = 1'b1;
    localparam logic       WRITE      = 1'b0;
    localparam logic [3:0] MEMORY     = 4'b0001;
    localparam logic [3:0] MMIO       = 4'b0011;
    localparam int         LINE_BYTES = 64;

    // reqtag/resptag layout: {rw[12], type[11:8], id[7:0]}
    typedef struct packed {
        logic       rw;
        logic [3:0] typ;
        logic [7:0] id;
    } tag_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } resp_state_t;

endpackage

// File: rtl/sysbus_mem_responder_if.sv
// Sysbus request/response bundle.
// Purpose: groups the request and response signals between a requester
// (master) and the memory responder (slave).
// Ports (signals):
//   reqcyc/req/reqtag : requester -> responder, header or write-data beat
//   reqack            : responder -> requester, one-cycle acknowledge
//   respcyc/resp/resptag : responder -> requester, read beat
//   respack           : requester -> responder, beat consumed
// Handshake: on the request side the requester holds reqcyc/req steady until
// it sees reqack, which the responder raises for exactly one cycle per accepted
// header or data beat; request cycles seen while reqack is high are ignored.
// On the response side a beat transfers on a cycle with respcyc && respack;
// while respack is low, respcyc/resp/resptag stay stable.
interface sysbus_mem_responder_if #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 13
);
    logic                  reqcyc;
    logic [DATA_WIDTH-1:0] req;
    logic [TAG_WIDTH-1:0]  reqtag;
    logic                  reqack;
    logic                  respcyc;
    logic [DATA_WIDTH-1:0] resp;
    logic [TAG_WIDTH-1:0]  resptag;
    logic                  respack;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );
endinterface

// File: rtl/sysbus_mem_array.sv
// Backing store for the Sysbus memory responder.
// Purpose: single-port word array, one write port, synchronous read (data
// appears the cycle after the address).
// Ports:
//   clk   : clock
//   addr  : word index shared by read and write
//   we    : write enable
//   wdata : write data
//   rdata : registered read data of the previous cycle's addr
module sysbus_mem_array #(
  parameter int DATA_WIDTH = 64,
  parameter int MEM_WORDS  = 4096,
  parameter     INIT_FILE  = ""
) (
  input  logic                         clk,
  input  logic [$clog2(MEM_WORDS)-1:0] addr,
  input  logic                         we,
  input  logic [DATA_WIDTH-1:0]        wdata,
  output logic [DATA_WIDTH-1:0]        rdata
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory responder.
// Purpose: accepts one line request at a time; reads stream LINE_BEATS words
// from the line base upward after READ_LATENCY cycles, writes absorb
// LINE_BEATS data beats. Non-MEMORY reads return zeros, non-MEMORY writes are
// acknowledged and dropped.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : Sysbus slave modport (request and response channels)
//   dbg_state  : current FSM state
//   dbg_beat   : current beat index
module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int TAG_WIDTH    = 13,
    parameter int LINE_BEATS   = 8,
    parameter int MEM_WORDS    = 4096,
    parameter int READ_LATENCY = 4,
    parameter     INIT_FILE    = ""
) (
    input  logic                            clk,
    input  logic                            reset,
    sysbus_mem_responder_if.slave           bus,
    output resp_state_t                     dbg_state,
    output logic [$clog2(LINE_BEATS)-1:0]   dbg_beat
);

    localparam int AW       = $clog2(MEM_WORDS);
    localparam int BW       = $clog2(LINE_BEATS);
    localparam int LW       = AW - BW;
    localparam int CW       = $clog2(READ_LATENCY);
    // Byte address bit where the line index starts (64 B line -> bit 6).
    localparam int LINE_LSB = $clog2(DATA_WIDTH / 8) + BW;
    localparam int LINE_MSB = LINE_LSB + LW - 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_BEATS - 1);

    resp_state_t          state_q, state_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [LW-1:0]        line_q, line_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic                 reqack_q, reqack_d;

    logic                  accept;
    logic                  is_mem;
    logic [BW-1:0]         rd_beat;
    logic [AW-1:0]         mem_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // A request cycle that overlaps our own reqack is the requester still
    // holding the item we just took, so it is not a new item.
    assign accept = bus.reqcyc && !reqack_q;
    assign is_mem = (tag_q[TAG_WIDTH-2 -: 4] == MEMORY);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            cnt_q    <= '0;
            line_q   <= '0;
            tag_q    <= '0;
            reqack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            cnt_q    <= cnt_d;
            line_q   <= line_d;
            tag_q    <= tag_d;
            reqack_q <= reqack_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        cnt_d    = cnt_q;
        line_d   = line_q;
        tag_d    = tag_q;
        reqack_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    // Low address bits are dropped and high bits beyond the
                    // array wrap silently.
                    line_d   = bus.req[LINE_MSB:LINE_LSB];
                    tag_d    = bus.reqtag;
                    reqack_d = 1'b1;
                    beat_d   = '0;
                    if (bus.reqtag[TAG_WIDTH-1] == READ) begin
                        state_d = WAIT;
                        cnt_d   = CW'(READ_LATENCY - 1);
                    end else begin
                        state_d = WDATA;
                    end
                end
            end
            WDATA: begin
                if (accept) begin
                    reqack_d = 1'b1;
                    beat_d   = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (bus.respack) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs and array control. The array read is issued one cycle ahead of
    // the beat it serves: beat 0 while waiting, beat+1 on an ack, otherwise
    // the current beat again so a stalled beat keeps its data.
    always_comb begin
        rd_beat = beat_q;
        if (state_q == WAIT) begin
            rd_beat = '0;
        end else if (state_q == RESP && bus.respack) begin
            rd_beat = beat_q + 1'b1;
        end
        mem_addr    = {line_q, rd_beat};
        mem_we      = (state_q == WDATA) && accept && is_mem;
        bus.reqack  = reqack_q;
        bus.respcyc = (state_q == RESP);
        bus.resp    = (state_q == RESP && is_mem) ? mem_rdata : '0;
        bus.resptag = tag_q;
        dbg_state   = state_q;
        dbg_beat    = beat_q;
    end

    sysbus_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS),
        .INIT_FILE  (INIT_FILE)
    ) u_array (
        .clk   (clk),
        .addr  (mem_addr),
        .we    (mem_we),
        .wdata (bus.req),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Testbench for sysbus_mem_responder: directed scenarios plus randomized
// line reads/writes checked against a word-level memory model.
module tb_sysbus_mem_responder;
    import sysbus_pkg::*;

    localparam int DW = 64;
    localparam int TW = 13;
    localparam int MW = 4096;
    localparam int RL = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sysbus_mem_responder_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();
    resp_state_t dbg_state;
    logic [2:0]  dbg_beat;
    logic        stall_hold;

    assign bus.respack = bus.respcyc && !stall_hold;

    sysbus_mem_responder #(
        .DATA_WIDTH   (DW),
        .TAG_WIDTH    (TW),
        .LINE_BEATS   (8),
        .MEM_WORDS    (MW),
        .READ_LATENCY (RL),
        .INIT_FILE    ("")
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_beat  (dbg_beat)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mdl[int];
    int written_lines[$];
    int ack_cnt     = 0;
    int respcyc_cnt = 0;

    always @(posedge clk) begin
        if (bus.reqack)  ack_cnt++;
        if (bus.respcyc) respcyc_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TW-1:0] mk_tag(input logic rw, input logic [3:0] typ, input logic [7:0] id);
        tag_t t;
        t.rw  = rw;
        t.typ = typ;
        t.id  = id;
        return t;
    endfunction

    // Word index of beat b of the line containing byte address addr.
    function automatic int line_word(input logic [63:0] addr, input int b);
        logic [63:0] w;
        w = (((addr >> 6) << 3) + 64'(b)) % 64'(MW);
        return int'(w);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_item(input logic [63:0] data, input logic [TW-1:0] tag);
        int lat;
        if (bus.reqack) tick();
        bus.reqcyc = 1'b1;
        bus.req    = data;
        bus.reqtag = tag;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.reqack && lat < 20);
        bus.reqcyc = 1'b0;
        check("ack_latency", 64'(lat), 64'd1);
    endtask

    task automatic wr_line(input logic [63:0] addr, input logic [3:0] typ,
                           input logic [63:0] d[8], input int gap_after);
        int a0;
        int r0;
        logic [TW-1:0] tag;
        a0  = ack_cnt;
        r0  = respcyc_cnt;
        tag = mk_tag(WRITE, typ, 8'($urandom_range(0, 255)));
        send_item(addr, tag);
        for (int b = 0; b < 8; b++) begin
            send_item(d[b], tag);
            if (b == gap_after) begin
                tick();
                tick();
            end
        end
        tick();
        tick();
        check("wr_ack_pulses", 64'(ack_cnt - a0), 64'd9);
        check("wr_no_resp", 64'(respcyc_cnt - r0), 64'd0);
        check("wr_state", 64'(dbg_state), 64'(IDLE));
        if (typ == MEMORY) begin
            for (int b = 0; b < 8; b++) mdl[line_word(addr, b)] = d[b];
        end
    endtask

    task automatic rd_line(input logic [63:0] addr, input logic [3:0] typ,
                           input logic [7:0] id, input logic [7:0] stall_mask);
        logic [TW-1:0] tag;
        logic [DW-1:0] e;
        int wait_c;
        int len;
        int nstall;
        tag = mk_tag(READ, typ, id);
        exp_q.delete();
        nstall = 0;
        for (int b = 0; b < 8; b++) begin
            if (typ == MEMORY && mdl.exists(line_word(addr, b)))
                exp_q.push_back(mdl[line_word(addr, b)]);
            else
                exp_q.push_back('0);
            if (stall_mask[b]) nstall++;
        end
        send_item(addr, tag);
        wait_c = 0;
        do begin
            tick();
            wait_c++;
        end while (!bus.respcyc && wait_c < 50);
        check("rd_first_beat_latency", 64'(wait_c), 64'(RL));
        len = 1;
        for (int b = 0; b < 8; b++) begin
            e = exp_q.pop_front();
            check("rd_respcyc", 64'(bus.respcyc), 64'd1);
            check("rd_data", bus.resp, e);
            check("rd_tag", 64'(bus.resptag), 64'(tag));
            if (stall_mask[b]) begin
                stall_hold = 1'b1;
                repeat (3) begin
                    tick();
                    len++;
                    check("stall_respcyc", 64'(bus.respcyc), 64'd1);
                    check("stall_data", bus.resp, e);
                end
                stall_hold = 1'b0;
            end
            tick();
            if (b < 7) len++;
        end
        check("rd_end_respcyc", 64'(bus.respcyc), 64'd0);
        check("rd_stream_len", 64'(len), 64'(8 + 3 * nstall));
        check("rd_end_state", 64'(dbg_state), 64'(IDLE));
    endtask

    // ---------------- stimulus ----------------
    logic [63:0] wd[8];

    initial begin
        int wait_c;
        int r0;
        logic [63:0] a;
        stall_hold = 1'b0;
        bus.reqcyc = 1'b0;
        bus.req    = '0;
        bus.reqtag = '0;
        reset      = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        check("rst_reqack", 64'(bus.reqack), 64'd0);
        check("rst_respcyc", 64'(bus.respcyc), 64'd0);
        check("rst_resp", bus.resp, 64'd0);
        check("rst_resptag", 64'(bus.resptag), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        check("rst_beat", 64'(dbg_beat), 64'd0);

        // Preload lines 0 and 0x40.
        for (int i = 0; i < 8; i++) wd[i] = 64'h1111_1111_1111_1110 + 64'(i);
        wr_line(64'h0, MEMORY, wd, -1);
        for (int i = 0; i < 8; i++) wd[i] = {$urandom, $urandom};
        wr_line(64'h40, MEMORY, wd, -1);

        // Aligned read, id 0, then an unaligned address inside line 0x40.
        rd_line(64'h0, MEMORY, 8'h00, 8'h00);
        check("tag_0x1100", 64'(mk_tag(READ, MEMORY, 8'h00)), 64'h1100);
        rd_line(64'h7C, MEMORY, 8'h21, 8'h00);

        // Write with a 2-cycle gap after beat 3, then read it back.
        for (int i = 0; i < 8; i++) wd[i] = 64'hA0 + 64'(i);
        wr_line(64'h80, MEMORY, wd, 3);
        rd_line(64'h80, MEMORY, 8'h33, 8'h00);

        // Stalls on beats 2 and 5: 14-cycle stream.
        rd_line(64'h80, MEMORY, 8'h44, 8'b0010_0100);

        // Reset while streaming beat 4.
        send_item(64'h0, mk_tag(READ, MEMORY, 8'h55));
        wait_c = 0;
        do begin
            tick();
            wait_c++;
        end while (!bus.respcyc && wait_c < 50);
        repeat (4) tick();
        check("mid_beat", 64'(dbg_beat), 64'd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_respcyc", 64'(bus.respcyc), 64'd0);
        check("mid_rst_state", 64'(dbg_state), 64'(IDLE));
        r0 = respcyc_cnt;
        repeat (6) tick();
        check("mid_rst_no_beats", 64'(respcyc_cnt - r0), 64'd0);
        rd_line(64'h0, MEMORY, 8'h66, 8'h00);

        // Address wrap and non-MEMORY types.
        rd_line(64'(MW) * 64'd8, MEMORY, 8'h77, 8'h00);
        rd_line(64'h0, MMIO, 8'h88, 8'h00);
        for (int i = 0; i < 8; i++) wd[i] = 64'hDEAD_0000 + 64'(i);
        wr_line(64'h40, MMIO, wd, -1);
        rd_line(64'h40, MEMORY, 8'h99, 8'h00);

        // Randomized mix.
        written_lines = '{0, 1, 2};
        for (int n = 0; n < 16; n++) begin
            int line;
            logic [3:0] typ;
            typ = ($urandom_range(0, 3) == 0) ? MMIO : MEMORY;
            if ($urandom_range(0, 1) == 0) begin
                line = $urandom_range(0, 7);
                for (int i = 0; i < 8; i++) wd[i] = {$urandom, $urandom};
                a = 64'(line) * 64'd64 + 64'($urandom_range(0, 63));
                if ($urandom_range(0, 3) == 0) a = a + 64'(MW) * 64'd8;
                wr_line(a, typ, wd, $urandom_range(0, 8) - 1);
                if (typ == MEMORY) written_lines.push_back(line);
            end else begin
                line = written_lines[$urandom_range(0, written_lines.size() - 1)];
                a = 64'(line) * 64'd64 + 64'($urandom_range(0, 63));
                if ($urandom_range(0, 3) == 0) a = a + 64'(MW) * 64'd8;
                rd_line(a, typ, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
